game_control_fsm: RTL and testbench

GAME_CONTROL_FSM -- requirements
Module: game_control_fsm

---
 rtl/game_pkg.sv | 21 ++
 rtl/row_priority_enc.sv | 22 ++
 rtl/game_control_fsm.sv | 122 ++++++++++++
 tb/tb_game_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default sizes for the game sequencer.
// State enum plus board, gravity and line-counter widths.
package game_pkg;

  localparam int ROWS_DEF    = 20;
  localparam int DROP_W_DEF  = 26;
  localparam int LINES_W_DEF = 16;

  typedef enum logic [3:0] {
    PRE,
    BUF,
    LOAD,
    FALL,
    PAUSED,
    UPDATE,
    CHECK,
    CLEAR,
    OVER
  } state_e;

endpackage

// File: rtl/row_priority_enc.sv
// Finds the highest-numbered full row (bottom-most on the board).
// any flags that at least one row is full.
module row_priority_enc #(
  parameter int ROWS  = 20,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]  lines,
  output logic [ROW_W-1:0] idx,
  output logic             any
);

  // Later (higher) indices overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (lines[r]) idx = ROW_W'(r);
    end
  end

  assign any = |lines;

endmodule

// File: rtl/game_control_fsm.sv
// Falling-block game sequencer: spawn, gravity, merge and line clear.
// Outputs come from registers or the registered state, never inputs.
module game_control_fsm
  import game_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int DROP_W  = DROP_W_DEF,
  parameter int LINES_W = LINES_W_DEF,
  parameter int ROW_W   = $clog2(ROWS)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start_game,
  input  logic               pause,
  input  logic               filled_under,
  input  logic               spawn_blocked,
  input  logic [ROWS-1:0]    completed_lines,
  input  logic [DROP_W-1:0]  drop_period,
  output logic               load_block,
  output logic               drop_block,
  output logic               update_board_state,
  output logic               shift_down,
  output logic [ROW_W-1:0]   clear_row,
  output logic [LINES_W-1:0] lines_total,
  output logic [2:0]         combo,
  output logic               playing,
  output logic               game_over
);

  state_e state, nstate;

  logic [DROP_W-1:0]  cnt;
  logic [DROP_W-1:0]  lim;
  logic               tick;
  logic [ROW_W-1:0]   row_idx;
  logic               row_any;
  logic               load_q;
  logic               drop_q;
  logic [ROW_W-1:0]   row_q;
  logic [LINES_W-1:0] lines_q;
  logic [2:0]         combo_q;

  // A zero period behaves like one: tick every cycle.
  assign lim  = (drop_period == '0) ? '0 : drop_period - 1'b1;
  assign tick = (cnt >= lim);

  row_priority_enc #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_enc (
    .lines (completed_lines),
    .idx   (row_idx),
    .any   (row_any)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= PRE;
    else         state <= nstate;
  end

  // Next-state selection; pause outranks a gravity tick.
  always_comb begin
    nstate = state;
    unique case (state)
      PRE:    if (start_game) nstate = BUF;
      BUF:    if (!start_game) nstate = LOAD;
      LOAD:   nstate = spawn_blocked ? OVER : FALL;
      FALL: begin
        if (pause)                     nstate = PAUSED;
        else if (tick && filled_under) nstate = UPDATE;
      end
      PAUSED: if (!pause) nstate = FALL;
      UPDATE: nstate = CHECK;
      CHECK:  nstate = row_any ? CLEAR : LOAD;
      CLEAR:  nstate = CHECK;
      OVER:   if (start_game) nstate = BUF;
      default: nstate = PRE;
    endcase
  end

  // Gravity counter, scoring and registered strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      load_q  <= 1'b0;
      drop_q  <= 1'b0;
      row_q   <= '0;
      lines_q <= '0;
      combo_q <= '0;
    end else begin
      load_q <= (state == LOAD) && !spawn_blocked;
      drop_q <= (state == FALL) && !pause && tick && !filled_under;
      if (state == BUF && !start_game) begin
        cnt     <= '0;
        lines_q <= '0;
        combo_q <= '0;
      end
      if (state == FALL && !pause) cnt <= tick ? '0 : cnt + 1'b1;
      if (state == UPDATE) combo_q <= '0;
      if (state == CHECK) row_q <= row_idx;
      if (state == CLEAR) begin
        if (~&lines_q) lines_q <= lines_q + 1'b1;
        if (combo_q != 3'd7) combo_q <= combo_q + 3'd1;
      end
    end
  end

  // Output decode from registered state and registers.
  always_comb begin
    load_block         = load_q;
    drop_block         = drop_q;
    update_board_state = (state == UPDATE);
    shift_down         = (state == CLEAR);
    clear_row          = row_q;
    lines_total        = lines_q;
    combo              = combo_q;
    playing            = !(state == PRE || state == BUF || state == OVER);
    game_over          = (state == OVER);
  end

endmodule

// File: tb/tb_game_control_fsm.sv
// Bench for game_control_fsm: directed scenarios plus random play.
// A phase-name model predicts every output each cycle.
module tb_game_control_fsm;

  localparam int ROWS    = 20;
  localparam int DROP_W  = 26;
  localparam int LINES_W = 2;
  localparam int ROW_W   = 5;
  localparam int LMAX    = (1 << LINES_W) - 1;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               start_game = 1'b0;
  logic               pause = 1'b0;
  logic               filled_under = 1'b0;
  logic               spawn_blocked = 1'b0;
  logic [ROWS-1:0]    completed_lines = '0;
  logic [DROP_W-1:0]  drop_period = '0;
  logic               load_block;
  logic               drop_block;
  logic               update_board_state;
  logic               shift_down;
  logic [ROW_W-1:0]   clear_row;
  logic [LINES_W-1:0] lines_total;
  logic [2:0]         combo;
  logic               playing;
  logic               game_over;

  int checks = 0;
  int errors = 0;

  string ph;
  int    elapsed;
  int    m_lines;
  int    m_combo;
  int    m_row;
  bit    e_load;
  bit    e_drop;

  logic [ROWS-1:0] v;
  int              pc;
  bit              seen;

  game_control_fsm #(
    .ROWS    (ROWS),
    .DROP_W  (DROP_W),
    .LINES_W (LINES_W),
    .ROW_W   (ROW_W)
  ) dut (
    .clock              (clock),
    .resetn             (resetn),
    .start_game         (start_game),
    .pause              (pause),
    .filled_under       (filled_under),
    .spawn_blocked      (spawn_blocked),
    .completed_lines    (completed_lines),
    .drop_period        (drop_period),
    .load_block         (load_block),
    .drop_block         (drop_block),
    .update_board_state (update_board_state),
    .shift_down         (shift_down),
    .clear_row          (clear_row),
    .lines_total        (lines_total),
    .combo              (combo),
    .playing            (playing),
    .game_over          (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph      = "pre";
    elapsed = 0;
    m_lines = 0;
    m_combo = 0;
    m_row   = 0;
    e_load  = 0;
    e_drop  = 0;
  endtask

  task automatic model_step();
    int per;
    e_load = 0;
    e_drop = 0;
    per = (drop_period == '0) ? 1 : int'(drop_period);
    if (ph == "pre") begin
      if (start_game) ph = "buf";
    end else if (ph == "buf") begin
      if (!start_game) begin
        ph = "load"; m_lines = 0; m_combo = 0; elapsed = 0;
      end
    end else if (ph == "load") begin
      if (spawn_blocked) ph = "over";
      else begin e_load = 1; ph = "fall"; end
    end else if (ph == "fall") begin
      if (pause) ph = "paused";
      else if (elapsed + 1 >= per) begin
        elapsed = 0;
        if (filled_under) ph = "update";
        else e_drop = 1;
      end else elapsed++;
    end else if (ph == "paused") begin
      if (!pause) ph = "fall";
    end else if (ph == "update") begin
      m_combo = 0; ph = "check";
    end else if (ph == "check") begin
      if (completed_lines != '0) begin
        m_row = $clog2(int'(completed_lines) + 1) - 1;
        ph = "clear";
      end else ph = "load";
    end else if (ph == "clear") begin
      if (m_lines < LMAX) m_lines++;
      if (m_combo < 7) m_combo++;
      ph = "check";
    end else if (ph == "over") begin
      if (start_game) ph = "buf";
    end
  endtask

  task automatic check_all();
    chk("load_block", 32'(load_block), 32'(e_load));
    chk("drop_block", 32'(drop_block), 32'(e_drop));
    chk("update_board_state", 32'(update_board_state), 32'(ph == "update"));
    chk("shift_down", 32'(shift_down), 32'(ph == "clear"));
    if (ph == "clear") chk("clear_row", 32'(clear_row), 32'(m_row));
    chk("lines_total", 32'(lines_total), 32'(m_lines));
    chk("combo", 32'(combo), 32'(m_combo));
    chk("playing", 32'(playing),
        32'(!(ph == "pre" || ph == "buf" || ph == "over")));
    chk("game_over", 32'(game_over), 32'(ph == "over"));
  endtask

  task automatic step();
    if (!resetn) model_reset();
    else model_step();
    @(posedge clock);
    #1;
    check_all();
    if (ph == "clear") completed_lines[m_row] = 1'b0;
  endtask

  initial begin
    model_reset();
    step();
    step();
    resetn = 1'b1;

    // gravity cadence with period 4
    drop_period = 26'd4;
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    step();
    step();
    chk("load_strobe", 32'(load_block), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("drop_cadence", 32'(drop_block), 32'(k % 4 == 0));
    end

    // pause at count 2 for ten cycles
    step();
    step();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("paused_no_drop", 32'(drop_block), 32'd0);
      chk("paused_playing", 32'(playing), 32'd1);
    end
    pause = 1'b0;
    step();
    chk("release_1", 32'(drop_block), 32'd0);
    step();
    chk("release_2", 32'(drop_block), 32'd0);
    step();
    chk("release_tick", 32'(drop_block), 32'd1);

    // landing with rows 19 and 0 full
    filled_under = 1'b1;
    completed_lines = 20'h80001;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = (ph == "update");
    end
    chk("reach_update", 32'(seen), 32'd1);
    chk("update_strobe", 32'(update_board_state), 32'd1);
    step();
    step();
    chk("first_clear_row", 32'(clear_row), 32'd19);
    chk("first_shift", 32'(shift_down), 32'd1);
    step();
    step();
    chk("second_clear_row", 32'(clear_row), 32'd0);
    chk("second_shift", 32'(shift_down), 32'd1);
    step();
    chk("combo_two", 32'(combo), 32'd2);
    chk("lines_two", 32'(lines_total), 32'd2);
    step();
    step();
    chk("load_after_clear", 32'(load_block), 32'd1);

    // many rows at once: counters saturate
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = (ph == "update");
    end
    chk("reach_update_2", 32'(seen), 32'd1);
    v = 20'($urandom) | 20'h0FF00;
    pc = $countones(v);
    completed_lines = v;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = (ph == "load");
    end
    chk("reach_load", 32'(seen), 32'd1);
    chk("lines_saturate", 32'(lines_total), 32'(LMAX));
    chk("combo_saturate", 32'(combo), 32'(pc > 7 ? 7 : pc));

    // blocked spawn ends the game, restart clears score
    spawn_blocked = 1'b1;
    step();
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_no_load", 32'(load_block), 32'd0);
    chk("over_keeps_lines", 32'(lines_total), 32'(LMAX));
    step();
    chk("over_hold", 32'(game_over), 32'd1);
    start_game = 1'b1;
    spawn_blocked = 1'b0;
    step();
    chk("buf_not_playing", 32'(playing), 32'd0);
    chk("buf_not_over", 32'(game_over), 32'd0);
    start_game = 1'b0;
    step();
    chk("restart_lines", 32'(lines_total), 32'd0);
    chk("restart_combo", 32'(combo), 32'd0);
    chk("restart_playing", 32'(playing), 32'd1);
    step();

    // random play
    for (int n = 0; n < 400; n++) begin
      start_game = ($urandom_range(0, 15) == 0);
      pause = ($urandom_range(0, 7) == 0);
      filled_under = ($urandom_range(0, 2) == 0);
      spawn_blocked = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        drop_period = DROP_W'($urandom_range(0, 5));
      step();
      if (ph == "update")
        completed_lines = ($urandom_range(0, 1) == 1) ?
                          (20'($urandom) & 20'h0C0F3) : '0;
    end

    // reset in the middle of a clear
    pause = 1'b0;
    spawn_blocked = 1'b0;
    filled_under = 1'b1;
    drop_period = 26'd1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      start_game = (ph == "pre" || ph == "over");
      step();
      if (ph == "update") completed_lines = 20'h00410;
      seen = (ph == "clear");
    end
    chk("reach_clear", 32'(seen), 32'd1);
    start_game = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_shift", 32'(shift_down), 32'd0);
    chk("async_row", 32'(clear_row), 32'd0);
    chk("async_playing", 32'(playing), 32'd0);
    chk("async_lines", 32'(lines_total), 32'd0);
    chk("async_combo", 32'(combo), 32'd0);
    chk("async_strobes",
        32'({load_block, drop_block, update_board_state, game_over}), 32'd0);
    model_reset();
    completed_lines = '0;
    step();
    resetn = 1'b1;
    step();
    chk("pre_idle", 32'(playing), 32'd0);
    start_game = 1'b1;
    step();
    chk("pre_to_buf", 32'(playing), 32'd0);
    start_game = 1'b0;
    step();
    chk("buf_to_load", 32'(playing), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
